// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// ------------
// Byte buffer between a data producer and uart_tx. The producer writes
// single bytes with a one-cycle strobe; the oldest stored byte is offered
// to uart_tx over a first-word-fall-through valid/ready handshake, so the
// producer never waits for a serial frame to finish.
//
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        synchronous reset, active-low
//   wr_en     in   1        producer write strobe, one byte per cycle
//   wr_data   in   WIDTH    producer byte
//   full      out  1        high when count == DEPTH (registered)
//   ovf       out  1        sticky overflow flag (registered)
//   ovf_clr   in   1        clears ovf; a same-cycle overflow wins
//   count     out  AW+1     stored bytes, 0..DEPTH (registered)
//   tx_data   out  WIDTH    head byte (combinational read of storage)
//   tx_valid  out  1        head byte present (registered)
//   tx_ready  in   1        uart_tx can take a byte this cycle
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wa;
  logic             ra;
  logic [AW:0]      count_next;

  // Handshake decode and next fill level. Acceptance looks only at the
  // registered full flag, so a write while full is dropped even when a
  // read frees a slot in the same cycle.
  always_comb begin
    wa         = wr_en & ~full;
    ra         = tx_valid & tx_ready;
    count_next = count;
    case ({wa, ra})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage array; not cleared by reset, and a write coinciding with
  // reset is discarded along with the pointers.
  always_ff @(posedge clk) begin
    if (rst && wa) begin
      mem[wp] <= wr_data;
    end
  end

  // Pointers, fill level and the flags derived from it. full and
  // tx_valid are kept as registers alongside count so that neither
  // wr_en nor tx_ready reaches an output flag combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= CNT_ZERO;
      full     <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      if (wa) begin
        wp <= wp + PTR_ONE;
      end
      if (ra) begin
        rp <= rp + PTR_ONE;
      end
      count    <= count_next;
      full     <= (count_next == CNT_FULL);
      tx_valid <= (count_next != CNT_ZERO);
    end
  end

  // Sticky overflow: a write attempt while full sets it, ovf_clr clears
  // it, and set has priority when both happen together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

  // First-word-fall-through head byte.
  assign tx_data = mem[rp];

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             ovf;
  logic             ovf_clr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;

  // Reference model: occupancy, sticky flag and the queue of bytes still
  // owed to the consumer.
  int             mdl_cnt = 0;
  bit             mdl_ovf = 1'b0;
  logic [7:0]     exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update at each active edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    if (!rst) begin
      mdl_cnt <= 0;
      mdl_ovf <= 1'b0;
      exp_q.delete();
    end else begin
      if (wr_en && mdl_cnt == DEPTH) mdl_ovf <= 1'b1;
      else if (ovf_clr) mdl_ovf <= 1'b0;
      if (wr_en && mdl_cnt < DEPTH) exp_q.push_back(wr_data);
      mdl_cnt <= mdl_cnt + ((wr_en && mdl_cnt < DEPTH) ? 1 : 0)
                         - ((mdl_cnt != 0 && tx_ready) ? 1 : 0);
    end
  end

  // Monitor on the falling edge: flags against the model, and every
  // handshake about to complete against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(mdl_cnt));
      chk("tx_valid", 32'(tx_valid), 32'(mdl_cnt != 0));
      chk("full", 32'(full), 32'(mdl_cnt == DEPTH));
      chk("ovf", 32'(ovf), 32'(mdl_ovf));
      if (rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; tx_ready = 1'b0;

    // Reset for two cycles, then a single byte.
    step();
    mon_en = 1'b1;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("single_valid", 32'(tx_valid), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_count", 32'(count), 32'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("single_drained", 32'(count), 32'd0);

    // Fill to full, then one dropped write.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("fill_ovf", 32'(ovf), 32'd1);
    chk("fill_count_kept", 32'(count), 32'd16);
    chk("fill_head", 32'(tx_data), 32'h00);
    tx_ready = 1'b1;
    repeat (DEPTH) step();
    tx_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(tx_valid), 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Write-3 / read-3 bursts so the pointers wrap.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        wr_en = 1'b1; wr_data = 8'($urandom);
        step();
      end
      wr_en = 1'b0;
      chk("wrap_count3", 32'(count), 32'd3);
      tx_ready = 1'b1;
      repeat (3) step();
      tx_ready = 1'b0;
      chk("wrap_empty", 32'(count), 32'd0);
    end

    // Read and overflowing write together at full.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    wr_data = 8'h55; tx_ready = 1'b1;
    step();
    wr_en = 1'b0; tx_ready = 1'b0;
    chk("rw_full_count", 32'(count), 32'd15);
    chk("rw_full_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_alone", 32'(ovf), 32'd0);
    wr_en = 1'b1; wr_data = 8'h11;
    step();
    chk("refill_full", 32'(full), 32'd1);
    wr_data = 8'h77; ovf_clr = 1'b1;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("set_beats_clr", 32'(ovf), 32'd1);
    tx_ready = 1'b1;
    repeat (DEPTH) step();
    tx_ready = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("rw_drained", 32'(count), 32'd0);

    // Reset in the middle of operation with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    chk("mid_count5", 32'(count), 32'd5);
    rst = 1'b0; wr_data = 8'hEE;
    step();
    rst = 1'b1; wr_en = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    chk("mid_first_data", 32'(tx_data), 32'h3C);
    chk("mid_first_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;

    // Randomized traffic: write-heavy half, then read-heavy half.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      b        = 8'($urandom);
      wr_data  = b;
      if (c < 2000) begin
        wr_en    = ($urandom_range(0, 3) != 0);
        tx_ready = ($urandom_range(0, 1) != 0);
      end else begin
        wr_en    = ($urandom_range(0, 1) != 0);
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; tx_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_empty", 32'(count), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
